// File: rtl/vga_game_pkg.sv
// Shared constants, types and per-axis move helpers for the VGA game object.
// VGA_SPRITE_WRAP_EN selects wrap-around instead of saturation at the border.
package vga_game_pkg;

    localparam int DEF_SCREEN_W  = 640;
    localparam int DEF_SCREEN_H  = 480;
    localparam int DEF_BORDER    = 10;
    localparam int DEF_OBJ_SIZE  = 30;
    localparam int DEF_START_X   = 320;
    localparam int DEF_START_Y   = 240;

    typedef logic [9:0] coord_t;

    typedef enum logic {IDLE, STEP} state_t;

    typedef struct packed {
        coord_t pos;
        logic   sat;
    } axis_res_t;

    // Opposing presses cancel out.
    function automatic logic signed [10:0] axis_delta(input logic neg, input logic pos,
                                                      input int step);
        logic signed [10:0] s;
        s = 11'(step);
        if (neg && !pos)
            return -s;
        else if (pos && !neg)
            return s;
        else
            return '0;
    endfunction

    function automatic axis_res_t step_axis(input coord_t pos, input logic signed [10:0] delta,
                                            input coord_t lo, input coord_t hi);
        logic signed [10:0] sum;
        axis_res_t          res;
        sum     = $signed({1'b0, pos}) + delta;
        res.pos = sum[9:0];
        res.sat = 1'b0;
        if (sum < $signed({1'b0, lo})) begin
`ifdef VGA_SPRITE_WRAP_EN
            res.pos = hi;
`else
            res.pos = lo;
            res.sat = (delta != '0);
`endif
        end else if (sum > $signed({1'b0, hi})) begin
`ifdef VGA_SPRITE_WRAP_EN
            res.pos = lo;
`else
            res.pos = hi;
            res.sat = (delta != '0);
`endif
        end
        return res;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-FF synchronizer plus frame-rate debounce for one raw active-low switch.
module switch_debounce #(
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic frame_tick,
    input  logic raw_n,
    output logic pressed
);
    import vga_game_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_FRAMES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q;
    logic          sync_pressed;

    assign sync_pressed = ~sync_q[1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            pressed <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw_n};
            if (frame_tick) begin
                if (sync_pressed != pressed) begin
                    if (cnt_q == CNT_LAST) begin
                        pressed <= sync_pressed;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/vga_sprite_mover.sv
// Frame-synchronous game object position controller; moves only in vertical blank.
// Build option: VGA_SPRITE_WRAP_EN wraps the position at the border instead of clamping.
module vga_sprite_mover #(
    parameter int SCREEN_W        = vga_game_pkg::DEF_SCREEN_W,
    parameter int SCREEN_H        = vga_game_pkg::DEF_SCREEN_H,
    parameter int BORDER          = vga_game_pkg::DEF_BORDER,
    parameter int OBJ_SIZE        = vga_game_pkg::DEF_OBJ_SIZE,
    parameter int START_X         = vga_game_pkg::DEF_START_X,
    parameter int START_Y         = vga_game_pkg::DEF_START_Y,
    parameter int FRAME_DIV       = 2,
    parameter int DEBOUNCE_FRAMES = 3,
    parameter int STEP            = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       frame_tick,
    input  logic       up_switch,
    input  logic       dn_switch,
    input  logic       left_switch,
    input  logic       right_switch,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       hit_wall,
    output logic       moving
);
    import vga_game_pkg::*;

    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);

    localparam coord_t X_MIN = coord_t'(BORDER);
    localparam coord_t X_MAX = coord_t'(SCREEN_W - BORDER - OBJ_SIZE);
    localparam coord_t Y_MIN = coord_t'(BORDER);
    localparam coord_t Y_MAX = coord_t'(SCREEN_H - BORDER - OBJ_SIZE);

    // Bit order: up, dn, left, right.
    logic [3:0] raw_n;
    logic [3:0] pressed;

    assign raw_n = {up_switch, dn_switch, left_switch, right_switch};

    for (genvar i = 0; i < 4; i++) begin : g_sw
        switch_debounce #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
        ) u_deb (
            .CLK       (CLK),
            .RST       (RST),
            .frame_tick(frame_tick),
            .raw_n     (raw_n[i]),
            .pressed   (pressed[i])
        );
    end

    state_t            state_q, state_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    if (fcnt_q == FC_LAST) begin
                        fcnt_d  = '0;
                        state_d = vga_game_pkg::STEP;
                    end else begin
                        fcnt_d = fcnt_q + 1'b1;
                    end
                end
            end
            vga_game_pkg::STEP: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    logic signed [10:0] dx, dy;
    axis_res_t          x_res, y_res;

    assign dx    = axis_delta(pressed[1], pressed[0], STEP);
    assign dy    = axis_delta(pressed[3], pressed[2], STEP);
    assign x_res = step_axis(o_x, dx, X_MIN, X_MAX);
    assign y_res = step_axis(o_y, dy, Y_MIN, Y_MAX);

    // Position only changes in the STEP cycle, which always falls inside vertical blank.
    always_ff @(posedge CLK) begin
        if (RST) begin
            o_x      <= coord_t'(START_X);
            o_y      <= coord_t'(START_Y);
            hit_wall <= 1'b0;
            moving   <= 1'b0;
        end else begin
            moving   <= |pressed;
            hit_wall <= 1'b0;
            if (state_q == vga_game_pkg::STEP) begin
                o_x      <= x_res.pos;
                o_y      <= y_res.pos;
                hit_wall <= x_res.sat | y_res.sat;
            end
        end
    end

endmodule
